// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, NOP encoding, PCsrc select codes, InstType codes.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EXEC = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  // addi x0,x0,0 -- architecturally a no-op, safe to drive when idle.
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // PCsrc codes from the controller; 2'b11 is reserved and behaves as PC_PLUS4.
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  // InstType codes, matching the controller's encoding.
  localparam logic [1:0] INST_I = 2'b00;
  localparam logic [1:0] INST_S = 2'b01;
  localparam logic [1:0] INST_B = 2'b10;
  localparam logic [1:0] INST_J = 2'b11;

endpackage

// File: rtl/imm_gen_bj.sv
// Branch/jump immediate extraction with sign extension.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of inputs).
// Ports: inst_hi = inst[31:7] (opcode bits carry no immediate), inst_type
// selects J-format when INST_J, B-format otherwise; imm = 32-bit offset.
module imm_gen_bj
  import fetch_pkg::*;
(
  input  logic [31:7] inst_hi,
  input  logic [1:0]  inst_type,
  output logic [31:0] imm
);

  always_comb begin
    if (inst_type == INST_J) begin
      imm = {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12], inst_hi[20],
             inst_hi[30:21], 1'b0};
    end else begin
      imm = {{19{inst_hi[31]}}, inst_hi[31], inst_hi[7], inst_hi[30:25],
             inst_hi[11:8], 1'b0};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction register and fetch FSM.
// Latency: >= 3 cycles per instruction (REQ handshake, WAIT for rvalid, EXEC).
// Backpressure: request held with stable address while imem_ready is low;
// WAIT extends until imem_rvalid; inst_valid is high for exactly one EXEC cycle.
// Ports: clk/nrst (async active-low); PCsrc/InstType/alu_result from the
// controller, sampled at the EXEC edge; imem_* ready/valid memory interface;
// inst/inst_valid/pc/pc_plus4 to the datapath; fetch_fault misalignment flag.
// Option: define FETCH_MISALIGN_TRAP_EN to halt on a misaligned next PC;
// otherwise the low two bits of the next PC are cleared and fetch_fault is 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  PCsrc,
  input  logic [1:0]  InstType,
  input  logic [31:0] alu_result,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  state_t      state, state_nxt;
  logic [31:0] inst_q;
  logic [31:0] imm;
  logic [31:0] next_raw;
  logic [31:0] next_pc;
  logic        pc_load;

  imm_gen_bj u_imm (
    .inst_hi   (inst_q[31:7]),
    .inst_type (InstType),
    .imm       (imm)
  );

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    next_raw = pc_plus4;
    unique case (PCsrc)
      PC_IMM:  next_raw = pc + imm;
      PC_JALR: next_raw = alu_result & ~32'h1;
      default: next_raw = pc_plus4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  logic fault_set;
  logic fault_q;

  assign next_pc     = next_raw;
  assign misaligned  = (next_raw[1:0] != 2'b00);
  assign fetch_fault = fault_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end
`else
  // Without trapping, misaligned targets are silently word-aligned.
  assign next_pc     = next_raw & ~32'h3;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    inst       = NOP_INST;
    inst_valid = 1'b0;
    pc_load    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_set  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        inst       = inst_q;
        inst_valid = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misaligned) begin
          fault_set = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          pc_load   = 1'b1;
          state_nxt = ST_REQ;
        end
`else
        pc_load   = 1'b1;
        state_nxt = ST_REQ;
`endif
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read data is only captured in WAIT, so responses left over from before a
  // reset (arriving in IDLE/REQ) never reach the instruction register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      inst_q <= NOP_INST;
    end else begin
      state <= state_nxt;
      if (pc_load) pc <= next_pc;
      if (state == ST_WAIT && imem_rvalid) inst_q <= imem_rdata;
    end
  end

endmodule
